dvp_axis_framer: RTL

- Sits directly downstream of the DVP capture controller's 64-bit AXI-Stream master, in the AXI clock domain.
- Adds video framing to the raw beat stream: tuser marks start-of-frame and tlast marks end-of-line.
- The output is suitable for a VDMA S2MM port.
- Beats per line and lines per frame are programmed from the register block. Both are latched at every frame boundary.

---
 rtl/dvp_axis_framer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/dvp_axis_framer.sv
// Video framer for a raw 64-bit AXI-Stream: tags tuser on start-of-frame and tlast on end-of-line.
// Optional statistics counters are built when DVP_FRAMER_STAT_EN is defined.
module dvp_axis_framer #(
   parameter int P_AXIS_DATA_WIDTH = 64,
   parameter int P_CNT_WIDTH       = 16
) (
   input  logic                         i_axi_clk,
   input  logic                         i_axi_rstn,
   input  logic                         i_ena,
   input  logic [P_CNT_WIDTH-1:0]       i_line_beats,
   input  logic [P_CNT_WIDTH-1:0]       i_frame_lines,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                         m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic                         o_cfg_err,
   output logic [15:0]                  o_frame_cnt,
   output logic [31:0]                  o_stall_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);

   // Handshake: a beat moves on a port in any cycle where valid and ready are both high at the rising edge.
   state_t                         state_q, state_d;
   logic [P_CNT_WIDTH-1:0]         lb_q, lb_d, fl_q, fl_d;
   logic [P_CNT_WIDTH-1:0]         beat_cnt_q, beat_cnt_d, line_cnt_q, line_cnt_d;
   logic                           sof_q, sof_d;
   logic                           stop_q, stop_d;
   logic                           cfg_err_q, cfg_err_d;
   logic                           s_ready_q, s_ready_d;
   logic                           busy_q, busy_d;
   logic                           m_valid_q, m_valid_d;
   logic [P_AXIS_DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                           m_user_q, m_user_d, m_last_q, m_last_d, m_eof_q, m_eof_d;
   logic                           sk_valid_q, sk_valid_d;
   logic [P_AXIS_DATA_WIDTH-1:0]   sk_data_q, sk_data_d;
   logic                           sk_user_q, sk_user_d, sk_last_q, sk_last_d, sk_eof_q, sk_eof_d;

   logic accept, out_fire, in_last, in_eof, cfg_ok;

   always_comb begin
      accept   = s_ready_q & s_axis_tvalid;
      out_fire = m_valid_q & m_axis_tready;
      in_last  = (beat_cnt_q == lb_q - CNT_ONE);
      in_eof   = in_last && (line_cnt_q == fl_q - CNT_ONE);
      cfg_ok   = (i_line_beats != '0) && (i_frame_lines != '0);

      state_d    = state_q;
      lb_d       = lb_q;
      fl_d       = fl_q;
      beat_cnt_d = beat_cnt_q;
      line_cnt_d = line_cnt_q;
      sof_d      = sof_q;
      stop_d     = stop_q;
      cfg_err_d  = cfg_err_q;

      case (state_q)
         ST_IDLE: begin
            if (i_ena) begin
               if (cfg_ok) begin
                  lb_d       = i_line_beats;
                  fl_d       = i_frame_lines;
                  beat_cnt_d = '0;
                  line_cnt_d = '0;
                  sof_d      = 1'b1;
                  stop_d     = 1'b0;
                  state_d    = ST_RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         default: begin
            // stop_q: the frame's last beat is in; wait for the skid buffer to flush before IDLE.
            if (stop_q) begin
               if (!m_valid_q && !sk_valid_q) state_d = ST_IDLE;
            end else begin
               if (accept) begin
                  sof_d = 1'b0;
                  if (in_last) begin
                     beat_cnt_d = '0;
                     line_cnt_d = in_eof ? '0 : line_cnt_q + CNT_ONE;
                  end else begin
                     beat_cnt_d = beat_cnt_q + CNT_ONE;
                  end
                  if (in_eof) begin
                     if (state_q == ST_RUN && i_ena && cfg_ok) begin
                        lb_d  = i_line_beats;
                        fl_d  = i_frame_lines;
                        sof_d = 1'b1;
                     end else begin
                        stop_d = 1'b1;
                        if (state_q == ST_RUN && i_ena) cfg_err_d = 1'b1;
                     end
                  end
               end
               if (!stop_d && state_q == ST_RUN && !i_ena) state_d = ST_DRAIN;
            end
         end
      endcase

      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_user_d   = m_user_q;
      m_last_d   = m_last_q;
      m_eof_d    = m_eof_q;
      sk_valid_d = sk_valid_q;
      sk_data_d  = sk_data_q;
      sk_user_d  = sk_user_q;
      sk_last_d  = sk_last_q;
      sk_eof_d   = sk_eof_q;

      // The input is only ready while the skid is empty, so accept and sk_valid_q never coincide.
      if (out_fire || !m_valid_q) begin
         if (sk_valid_q) begin
            m_valid_d  = 1'b1;
            m_data_d   = sk_data_q;
            m_user_d   = sk_user_q;
            m_last_d   = sk_last_q;
            m_eof_d    = sk_eof_q;
            sk_valid_d = 1'b0;
         end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_user_d  = sof_q;
            m_last_d  = in_last;
            m_eof_d   = in_eof;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept) begin
         sk_valid_d = 1'b1;
         sk_data_d  = s_axis_tdata;
         sk_user_d  = sof_q;
         sk_last_d  = in_last;
         sk_eof_d   = in_eof;
      end

      s_ready_d = (state_d != ST_IDLE) && !stop_d && !sk_valid_d;
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_axi_clk or negedge i_axi_rstn) begin
      if (!i_axi_rstn) begin
         state_q    <= ST_IDLE;
         lb_q       <= '0;
         fl_q       <= '0;
         beat_cnt_q <= '0;
         line_cnt_q <= '0;
         sof_q      <= 1'b0;
         stop_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_user_q   <= 1'b0;
         m_last_q   <= 1'b0;
         m_eof_q    <= 1'b0;
         sk_valid_q <= 1'b0;
         sk_data_q  <= '0;
         sk_user_q  <= 1'b0;
         sk_last_q  <= 1'b0;
         sk_eof_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lb_q       <= lb_d;
         fl_q       <= fl_d;
         beat_cnt_q <= beat_cnt_d;
         line_cnt_q <= line_cnt_d;
         sof_q      <= sof_d;
         stop_q     <= stop_d;
         cfg_err_q  <= cfg_err_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_user_q   <= m_user_d;
         m_last_q   <= m_last_d;
         m_eof_q    <= m_eof_d;
         sk_valid_q <= sk_valid_d;
         sk_data_q  <= sk_data_d;
         sk_user_q  <= sk_user_d;
         sk_last_q  <= sk_last_d;
         sk_eof_q   <= sk_eof_d;
      end
   end

   assign s_axis_tready = s_ready_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tlast  = m_last_q;
   assign o_busy        = busy_q;
   assign o_cfg_err     = cfg_err_q;
   assign o_frame_done  = m_valid_q & m_axis_tready & m_eof_q;

`ifdef DVP_FRAMER_STAT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      frame_cnt_d = o_frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (m_valid_q && !m_axis_tready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge i_axi_clk or negedge i_axi_rstn) begin
      if (!i_axi_rstn) begin
         frame_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`else
   assign o_frame_cnt = '0;
   assign o_stall_cnt = '0;
`endif

endmodule
